// File: rtl/bp_btb_predictor.sv
// Branch predictor: direct-mapped BTB plus a table of saturating direction counters.
// Lookup is combinational. Updates are registered, and the tables are read before they
// are written, so a lookup in the same cycle as an update sees the old state.
// Optional gshare counter indexing is enabled with the BP_GSHARE_EN macro.
module bp_btb_predictor #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ENTRIES   = 64,
  parameter int unsigned CTR_BITS  = 2,
  parameter int unsigned PERF_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [XLEN-1:0]      lookup_pc,
  output logic                 pred_hit,
  output logic                 pred_taken,
  output logic [XLEN-1:0]      pred_target,
  input  logic                 upd_valid,
  input  logic [XLEN-1:0]      upd_pc,
  input  logic                 upd_taken,
  input  logic [XLEN-1:0]      upd_target,
  input  logic                 upd_mispredict,
  output logic [PERF_BITS-1:0] perf_branches,
  output logic [PERF_BITS-1:0] perf_mispredicts
);

  localparam int unsigned IDX   = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX - 2;

  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_WNT = {1'b0, {(CTR_BITS - 1){1'b1}}};
  localparam logic [CTR_BITS-1:0] CTR_WT  = {1'b1, {(CTR_BITS - 1){1'b0}}};

  logic [ENTRIES-1:0]   valid_q;
  logic [TAG_W-1:0]     tag_q    [ENTRIES];
  logic [XLEN-1:0]      target_q [ENTRIES];
  logic [CTR_BITS-1:0]  ctr_q    [ENTRIES];
  logic [PERF_BITS-1:0] perf_branches_q;
  logic [PERF_BITS-1:0] perf_mispredicts_q;

  logic [IDX-1:0]      lk_idx, lk_cidx, up_idx, up_cidx;
  logic [TAG_W-1:0]    lk_tag, up_tag;
  logic                up_hit;
  logic [CTR_BITS-1:0] ctr_cur, ctr_nxt;

  // Byte offset within the word never selects an entry.
  logic unused_pc_bits;
  assign unused_pc_bits = ^upd_pc[1:0];

  assign lk_idx = lookup_pc[IDX+1:2];
  assign lk_tag = lookup_pc[XLEN-1:IDX+2];
  assign up_idx = upd_pc[IDX+1:2];
  assign up_tag = upd_pc[XLEN-1:IDX+2];

`ifdef BP_GSHARE_EN
  logic [IDX-1:0] ghr_q;

  // Global history: shift in each resolved outcome; accesses use the pre-shift value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr_q <= '0;
    end else if (upd_valid) begin
      ghr_q <= {ghr_q[IDX-2:0], upd_taken};
    end
  end

  assign lk_cidx = lk_idx ^ ghr_q;
  assign up_cidx = up_idx ^ ghr_q;
`else
  assign lk_cidx = lk_idx;
  assign up_cidx = up_idx;
`endif

  // Combinational prediction from the current table contents.
  always_comb begin
    pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken  = pred_hit && ctr_q[lk_cidx][CTR_BITS-1];
    pred_target = pred_taken ? target_q[lk_idx] : lookup_pc + XLEN'(4);
  end

  // Saturating step of the counter addressed by the resolving branch.
  always_comb begin
    up_hit  = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    ctr_cur = ctr_q[up_cidx];
    ctr_nxt = ctr_cur;
    if (upd_taken) begin
      if (ctr_cur != CTR_MAX) ctr_nxt = ctr_cur + CTR_BITS'(1);
    end else begin
      if (ctr_cur != '0) ctr_nxt = ctr_cur - CTR_BITS'(1);
    end
  end

  // Valid bits, direction counters and performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q            <= '0;
      perf_branches_q    <= '0;
      perf_mispredicts_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        ctr_q[i] <= CTR_WNT;
      end
    end else if (upd_valid) begin
      if (up_hit) begin
        ctr_q[up_cidx] <= ctr_nxt;
      end else if (upd_taken) begin
        valid_q[up_idx] <= 1'b1;
        ctr_q[up_cidx]  <= CTR_WT;
      end
      if (perf_branches_q != '1) perf_branches_q <= perf_branches_q + PERF_BITS'(1);
      if (upd_mispredict && (perf_mispredicts_q != '1)) begin
        perf_mispredicts_q <= perf_mispredicts_q + PERF_BITS'(1);
      end
    end
  end

  // Tag and target storage needs no reset; valid gates every use of it.
  always_ff @(posedge clk) begin
    if (rst && upd_valid && upd_taken) begin
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= upd_target;
    end
  end

  assign perf_branches    = perf_branches_q;
  assign perf_mispredicts = perf_mispredicts_q;

endmodule

// File: tb/tb_bp_btb_predictor.sv
// Self-checking bench for bp_btb_predictor (ENTRIES=64, CTR_BITS=2, PERF_BITS=4 so that
// performance-counter saturation is reachable). Expected lookups go into a scoreboard
// queue as stimulus is driven; sampled outputs are compared against it per scenario.
module tb_bp_btb_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_mispredict = 1'b0;
  logic [3:0]  perf_branches, perf_mispredicts;

  int checks = 0;
  int passed = 0;

  typedef struct {
    string       name;
    logic        hit;
    logic        taken;
    logic [31:0] target;
  } look_t;

  look_t exp_q[$];
  look_t obs_q[$];

  bp_btb_predictor #(
    .XLEN(32), .ENTRIES(64), .CTR_BITS(2), .PERF_BITS(4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .lookup_pc       (lookup_pc),
    .pred_hit        (pred_hit),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_mispredict  (upd_mispredict),
    .perf_branches   (perf_branches),
    .perf_mispredicts(perf_mispredicts)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
    $fatal(1);
  end

  // One cycle: drive lookup and optional update, record the expected and the sampled
  // (pre-update) prediction, then let the clock edge commit the update.
  task automatic drive_step(input string name, input bit upd, input logic [31:0] upc,
                            input bit utk, input logic [31:0] utgt, input logic [31:0] lpc,
                            input logic ehit, input logic etk, input logic [31:0] etgt);
    lookup_pc      = lpc;
    upd_valid      = upd;
    upd_pc         = upc;
    upd_taken      = utk;
    upd_target     = utgt;
    upd_mispredict = 1'b0;
    exp_q.push_back('{name, ehit, etk, etgt});
    #1;
    obs_q.push_back('{name, pred_hit, pred_taken, pred_target});
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    upd_valid = 1'b0;
    upd_mispredict = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    look_t e, o;
    rst       = 1'b0;
    lookup_pc = 32'h100;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (pred_hit !== 1'b0 || pred_taken !== 1'b0 || pred_target !== 32'h104)
      $display("FAIL reset_hold: hit/taken/target got %0b/%0b/%h want 0/0/00000104",
               pred_hit, pred_taken, pred_target);
    else passed++;
    checks++;
    if (perf_branches !== 4'd0 || perf_mispredicts !== 4'd0)
      $display("FAIL reset_perf: branches/mispredicts got %0d/%0d want 0/0",
               perf_branches, perf_mispredicts);
    else passed++;
    rst = 1'b1;
    drive_step("reset_release", 0, 0, 0, 0, 32'h100, 0, 0, 32'h104);
    drive_step("reset_wrap", 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 0, 32'h0);
    drive_step("reset_other_idx", 0, 0, 0, 0, 32'h1234_5678, 0, 0, 32'h1234_567C);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.hit !== e.hit || o.taken !== e.taken || o.target !== e.target)
        $display("FAIL %s: hit/taken/target got %0b/%0b/%h want %0b/%0b/%h",
                 e.name, o.hit, o.taken, o.target, e.hit, e.taken, e.target);
      else passed++;
    end
  endtask

  // Allocation on a taken miss, including a same-cycle lookup that sees the old state.
  task automatic test_alloc();
    look_t e, o;
    drive_step("alloc_same_cycle", 1, 32'h100, 1, 32'h40, 32'h100, 0, 0, 32'h104);
    drive_step("alloc_next_cycle", 0, 0, 0, 0, 32'h100, 1, 1, 32'h40);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.hit !== e.hit || o.taken !== e.taken || o.target !== e.target)
        $display("FAIL %s: hit/taken/target got %0b/%0b/%h want %0b/%0b/%h",
                 e.name, o.hit, o.taken, o.target, e.hit, e.taken, e.target);
      else passed++;
    end
  endtask

  // Counter walk on 0x100 starting from 10: both saturation ends and target handling.
  task automatic test_counter();
    look_t e, o;
    drive_step("ctr_10_nt", 1, 32'h100, 0, 32'h0, 32'h100, 1, 1, 32'h40);
    drive_step("ctr_01_nt", 1, 32'h100, 0, 32'h0, 32'h100, 1, 0, 32'h104);
    drive_step("ctr_00_nt_sat", 1, 32'h100, 0, 32'h0, 32'h100, 1, 0, 32'h104);
    drive_step("ctr_00_after_sat", 1, 32'h100, 1, 32'h44, 32'h100, 1, 0, 32'h104);
    drive_step("ctr_01_t", 1, 32'h100, 1, 32'h48, 32'h100, 1, 0, 32'h104);
    drive_step("ctr_10_t_target", 1, 32'h100, 1, 32'h4C, 32'h100, 1, 1, 32'h48);
    drive_step("ctr_11_t_sat", 1, 32'h100, 1, 32'h4C, 32'h100, 1, 1, 32'h4C);
    drive_step("ctr_11_after_sat", 1, 32'h100, 0, 32'h99, 32'h100, 1, 1, 32'h4C);
    drive_step("ctr_10_nt_keeps_target", 0, 0, 0, 0, 32'h100, 1, 1, 32'h4C);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.hit !== e.hit || o.taken !== e.taken || o.target !== e.target)
        $display("FAIL %s: hit/taken/target got %0b/%0b/%h want %0b/%0b/%h",
                 e.name, o.hit, o.taken, o.target, e.hit, e.taken, e.target);
      else passed++;
    end
  endtask

  // 0x200 aliases 0x100 at idx 0 with a different tag.
  task automatic test_alias();
    look_t e, o;
    drive_step("alias_lookup_miss", 0, 0, 0, 0, 32'h200, 0, 0, 32'h204);
    drive_step("alias_nt_miss", 1, 32'h200, 0, 32'h80, 32'h100, 1, 1, 32'h4C);
    drive_step("alias_nt_no_change", 0, 0, 0, 0, 32'h100, 1, 1, 32'h4C);
    drive_step("alias_replace", 1, 32'h200, 1, 32'h80, 32'h200, 0, 0, 32'h204);
    drive_step("alias_new_hit", 0, 0, 0, 0, 32'h200, 1, 1, 32'h80);
    drive_step("alias_old_miss", 0, 0, 0, 0, 32'h100, 0, 0, 32'h104);
    drive_step("alias_low_bits", 0, 0, 0, 0, 32'h202, 1, 1, 32'h80);
    drive_step("alias_idx1_miss", 0, 0, 0, 0, 32'h104, 0, 0, 32'h108);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.hit !== e.hit || o.taken !== e.taken || o.target !== e.target)
        $display("FAIL %s: hit/taken/target got %0b/%0b/%h want %0b/%0b/%h",
                 e.name, o.hit, o.taken, o.target, e.hit, e.taken, e.target);
      else passed++;
    end
  endtask

  // Reset mid-cycle clears outputs at once; updates during reset are dropped.
  task automatic test_async_reset();
    upd_valid = 1'b1;
    upd_pc    = 32'h300;
    upd_taken = 1'b1;
    upd_target = 32'h10;
    lookup_pc = 32'h300;
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    #1;
    checks++;
    if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h10)
      $display("FAIL async_pre: hit/taken/target got %0b/%0b/%h want 1/1/00000010",
               pred_hit, pred_taken, pred_target);
    else passed++;
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (pred_hit !== 1'b0 || pred_taken !== 1'b0 || pred_target !== 32'h304)
      $display("FAIL async_immediate: hit/taken/target got %0b/%0b/%h want 0/0/00000304",
               pred_hit, pred_taken, pred_target);
    else passed++;
    checks++;
    if (perf_branches !== 4'd0 || perf_mispredicts !== 4'd0)
      $display("FAIL async_perf: branches/mispredicts got %0d/%0d want 0/0",
               perf_branches, perf_mispredicts);
    else passed++;
    upd_valid = 1'b1;
    upd_mispredict = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    upd_valid = 1'b0;
    upd_mispredict = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (pred_hit !== 1'b0 || pred_target !== 32'h304 || perf_branches !== 4'd0)
      $display("FAIL async_discard: hit/target/branches got %0b/%h/%0d want 0/00000304/0",
               pred_hit, pred_target, perf_branches);
    else passed++;
  endtask

  task automatic test_perf();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      upd_valid = 1'b1;
      upd_pc = 32'h400;
      upd_taken = 1'b0;
      upd_mispredict = (i == 1) || (i == 3);
      @(posedge clk);
      #1;
    end
    upd_valid = 1'b0;
    upd_mispredict = 1'b1;
    @(posedge clk);
    #1;
    upd_mispredict = 1'b0;
    checks++;
    if (perf_branches !== 4'd5 || perf_mispredicts !== 4'd2)
      $display("FAIL perf_count: branches/mispredicts got %0d/%0d want 5/2",
               perf_branches, perf_mispredicts);
    else passed++;
    for (int i = 0; i < 15; i++) begin
      upd_valid = 1'b1;
      upd_mispredict = 1'b1;
      @(posedge clk);
      #1;
    end
    upd_valid = 1'b0;
    upd_mispredict = 1'b0;
    checks++;
    if (perf_branches !== 4'hF || perf_mispredicts !== 4'hF)
      $display("FAIL perf_saturate: branches/mispredicts got %0d/%0d want 15/15",
               perf_branches, perf_mispredicts);
    else passed++;
  endtask

`ifdef BP_GSHARE_EN
  // After taken,taken the GHR is 0b11, so a lookup of 0x100 reads counter 3 (still 01).
  task automatic test_gshare();
    look_t e, o;
    do_reset();
    drive_step("gs_alloc", 1, 32'h100, 1, 32'h40, 32'h100, 0, 0, 32'h104);
    drive_step("gs_ghr1_ctr1", 1, 32'h100, 1, 32'h40, 32'h100, 1, 0, 32'h104);
    drive_step("gs_ghr3_ctr3", 0, 0, 0, 0, 32'h100, 1, 0, 32'h104);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.hit !== e.hit || o.taken !== e.taken || o.target !== e.target)
        $display("FAIL %s: hit/taken/target got %0b/%0b/%h want %0b/%0b/%h",
                 e.name, o.hit, o.taken, o.target, e.hit, e.taken, e.target);
      else passed++;
    end
  endtask
`endif

  initial begin
    test_reset();
`ifndef BP_GSHARE_EN
    test_alloc();
    test_counter();
    test_alias();
`endif
    test_async_reset();
    test_perf();
`ifdef BP_GSHARE_EN
    test_gshare();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/bp_btb_predictor.md
Name: bp_btb_predictor

Overview:
- Parametrised branch predictor for the rv32 pipeline: a direct-mapped branch target buffer plus a table of 2-bit saturating direction counters.
- Fetch gets a same-cycle prediction of taken/not-taken and the next PC.
- Execute writes back resolved branch outcomes.
- Successor to the fixed, non-predicting fetch path. Generalised in table depth, counter width and XLEN, with an optional gshare indexing mode.

Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 64, BTB and counter-table depth; power of 2, at least 4. IDX = log2(ENTRIES).
- CTR_BITS, 2, saturating counter width, at least 2.
- PERF_BITS, 32, width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted when 0).
- lookup_pc  in  XLEN  fetch PC.
- pred_hit  out  1  BTB tag hit for lookup_pc.
- pred_taken  out  1  predicted taken.
- pred_target  out  XLEN  predicted next PC.
- upd_valid  in  1  a resolved control-flow instruction this cycle.
- upd_pc  in  XLEN  PC of the resolved instruction.
- upd_taken  in  1  actual outcome.
- upd_target  in  XLEN  actual taken target.
- upd_mispredict  in  1  pipeline flushed for this instruction.
- perf_branches  out  PERF_BITS  count of upd_valid cycles.
- perf_mispredicts  out  PERF_BITS  count of upd_valid && upd_mispredict cycles.

Behaviour:
- Address split:
  - idx = pc[IDX+1:2].
  - tag = pc[XLEN-1:IDX+2].
  - pc[1:0] is ignored.
- Storage per entry:
  - valid bit, tag, target (XLEN).
  - One CTR_BITS counter per entry, in a separate array.
- Lookup (combinational, 0-cycle latency):
  - pred_hit = valid[idx] && tag[idx] == tag(lookup_pc).
  - pred_taken = pred_hit && counter MSB.
  - pred_target = pred_taken ? target[idx] : lookup_pc + 4 (wraps modulo 2^XLEN).
- Update (registered on rising clk when upd_valid=1):
  - Tag hit, taken: counter increments, saturating at all-ones; target is overwritten with upd_target.
  - Tag hit, not taken: counter decrements, saturating at 0; target is unchanged.
  - Tag miss, taken: the entry is allocated (replacing any alias). valid=1, tag and target written, counter set to 10..0 (weakly taken).
  - Tag miss, not taken: no change.
- Read/write ordering: the table is read-before-write. A lookup and an update to the same idx in the same cycle gives a lookup that sees the pre-update state; the new state is visible from the next cycle.
- Performance counters:
  - perf_branches increments on every upd_valid.
  - perf_mispredicts increments when upd_valid && upd_mispredict.
  - Both saturate at all-ones; neither wraps.
  - upd_mispredict without upd_valid is ignored.
- Reset (rst=0, asynchronous, any time including mid-update):
  - All valid bits cleared.
  - All counters set to 01..1 (weakly not-taken).
  - Perf counters set to 0.
  - Targets and tags are don't-care.
  - Resulting outputs: pred_hit=0, pred_taken=0, pred_target=lookup_pc+4, perf_*=0.
  - Updates presented while rst=0 are discarded.
- No stall input: lookup is purely combinational, so the fetch stage holds lookup_pc during stalls.

Optional Feature:
- Macro: BP_GSHARE_EN.
- When defined:
  - An IDX-bit global history register (GHR) is added; it resets to 0.
  - On each upd_valid, the GHR shifts left by one and upd_taken enters at bit 0.
  - The counter-table index becomes pc idx XOR GHR, for both lookup and update. Each access uses the GHR value present before that cycle's shift.
  - The BTB valid/tag/target arrays remain indexed by pc idx only.
  - pred_taken still requires pred_hit.
- When undefined: no GHR exists and the counter index equals the BTB idx.

Test Plan (ENTRIES=64, CTR_BITS=2, no BP_GSHARE_EN unless stated):
- Reset release, lookup_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104, perf_branches=0.
- Update pc=0x100, taken=1, target=0x40; next cycle lookup 0x100 -> hit=1, taken=1, target=0x40 (counter 10).
- From the previous state, update 0x100 not-taken once -> counter 01, lookup gives hit=1, taken=0, target=0x104. A second not-taken -> counter 00. Then two taken updates give counter 10 -> taken=1.
- Alias: with 0x100 allocated, lookup 0x200 (same idx 0) -> hit=0, target=0x204. A taken update on 0x200 to 0x80 replaces the entry; lookup 0x100 then misses.
- Same-cycle update and lookup on 0x100 after reset -> lookup shows taken=0; the following cycle shows taken=1. Assert rst=0 mid-sequence -> outputs return to reset values immediately, without waiting for a clock edge.
- 5 upd_valid with upd_mispredict on 2 of them -> perf_branches=5, perf_mispredicts=2. With BP_GSHARE_EN: taken,taken updates on 0x100 leave GHR=0b11, and a lookup of 0x100 uses counter index 3.
